// File: rtl/llc_input_arbiter_pkg.sv
// Shared LLC arbiter types: channel indices, the one-hot grant type,
// the FSM state encoding and the default response burst limit.
package llc_input_arbiter_pkg;

    localparam int ARB_RST = 0;
    localparam int ARB_RSP = 1;
    localparam int ARB_REQ = 2;
    localparam int ARB_DMA = 3;
    localparam int ARB_NCH = 4;

    // Response grants allowed back-to-back before a waiting request is forced in
    localparam int LLC_ARB_RSP_BURST_MAX = 4;

    // One-hot grant, bit order {dma, req, rsp, rst}
    typedef logic [ARB_NCH-1:0] arb_gnt_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/llc_arb_rr2.sv
// Two-way round-robin picker. The pointer starts on channel a. After a
// grant it moves to the channel that was not granted.
module llc_arb_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic upd_en,
    output logic pick_a,
    output logic pick_b
);

    logic ptr_q;

    // The pointer only matters when both channels request; a lone requester always wins
    always_comb begin
        pick_a = req_a & (~req_b | ~ptr_q);
        pick_b = req_b & (~req_a | ptr_q);
    end

    // Move the pointer to the channel that lost, but only when the picked channel is really granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (upd_en && (pick_a || pick_b)) begin
            ptr_q <= pick_a;
        end
    end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC input arbiter. Picks the next channel for the core's DECODE stage
// and holds that grant until the core reports completion with core_done.
// Priority order: testbench reset, then the forced request slot, then
// coherence response, then CPU/DMA request in round-robin.
// Optional feature: define LLC_ARB_STATS_EN to add saturating pop counters
// and a counter of forced request slots.
//
// state | meaning
// IDLE  | no transaction held; readies are live while core_idle is high
// BUSY  | grant is held; waiting for core_done
module llc_input_arbiter
    import llc_input_arbiter_pkg::*;
#(
    parameter int RSP_BURST_MAX = LLC_ARB_RSP_BURST_MAX,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_tb_valid,
    input  logic             rsp_in_valid,
    input  logic             req_in_valid,
    input  logic             dma_req_in_valid,
    input  logic             req_stall,
    input  logic             dma_stall,
    input  logic             core_idle,
    input  logic             core_done,
    output logic             rst_tb_ready,
    output logic             rsp_in_ready,
    output logic             req_in_ready,
    output logic             dma_req_in_ready,
    output logic [3:0]       gnt,
    output logic             busy
`ifdef LLC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_rst,
    output logic [CNT_W-1:0] stat_rsp,
    output logic [CNT_W-1:0] stat_req,
    output logic [CNT_W-1:0] stat_dma,
    output logic [CNT_W-1:0] stat_forced
`endif
);

    localparam int BW = $clog2(RSP_BURST_MAX + 1);

    arb_state_t    state;
    logic [BW-1:0] rsp_burst;
    arb_gnt_t      sel;
    arb_gnt_t      ready_vec;
    logic          req_elig;
    logic          dma_elig;
    logic          any_req;
    logic          burst_full;
    logic          arb_ok;
    logic          pick_req;
    logic          pick_dma;
    logic          rr_upd;

    // Work out which channels are eligible and whether arbitration is open this cycle
    always_comb begin
        req_elig   = req_in_valid & ~req_stall;
        dma_elig   = dma_req_in_valid & ~dma_stall;
        any_req    = req_elig | dma_elig;
        burst_full = (rsp_burst == BW'(RSP_BURST_MAX));
        // rst is included so the readies read zero while reset is held
        arb_ok     = rst & (state == ARB_IDLE) & core_idle;
    end

    llc_arb_rr2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_elig),
        .req_b  (dma_elig),
        .upd_en (rr_upd),
        .pick_a (pick_req),
        .pick_b (pick_dma)
    );

    // Fixed-priority selection; the first matching rule wins
    always_comb begin
        sel = '0;
        if (rst_tb_valid) begin
            sel[ARB_RST] = 1'b1;
        end else if (burst_full && any_req) begin
            sel[ARB_REQ] = pick_req;
            sel[ARB_DMA] = pick_dma;
        end else if (rsp_in_valid) begin
            sel[ARB_RSP] = 1'b1;
        end else begin
            sel[ARB_REQ] = pick_req;
            sel[ARB_DMA] = pick_dma;
        end
    end

    // Readies are combinational so a grant costs no cycles once the core is idle
    always_comb begin
        ready_vec        = arb_ok ? sel : '0;
        rst_tb_ready     = ready_vec[ARB_RST];
        rsp_in_ready     = ready_vec[ARB_RSP];
        req_in_ready     = ready_vec[ARB_REQ];
        dma_req_in_ready = ready_vec[ARB_DMA];
        rr_upd           = ready_vec[ARB_REQ] | ready_vec[ARB_DMA];
    end

    // Grant FSM: latch the grant, track the response burst, release on core_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_burst <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|ready_vec) begin
                        state <= ARB_BUSY;
                        gnt   <= ready_vec;
                        busy  <= 1'b1;
                        if (ready_vec[ARB_REQ] || ready_vec[ARB_DMA]) begin
                            rsp_burst <= '0;
                        end else if (ready_vec[ARB_RSP]) begin
                            if (!any_req) begin
                                rsp_burst <= '0;
                            end else if (!burst_full) begin
                                rsp_burst <= rsp_burst + BW'(1);
                            end
                        end
                    end
                end
                ARB_BUSY: begin
                    if (core_done) begin
                        state <= ARB_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LLC_ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic forced_pop;

    // A forced slot is a request grant taken while the response burst is full
    always_comb begin
        forced_pop = burst_full & (ready_vec[ARB_REQ] | ready_vec[ARB_DMA]);
    end

    // Saturating per-channel pop counters plus the forced-slot counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rst    <= '0;
            stat_rsp    <= '0;
            stat_req    <= '0;
            stat_dma    <= '0;
            stat_forced <= '0;
        end else begin
            if (ready_vec[ARB_RST] && rst_tb_valid)     stat_rst    <= sat_inc(stat_rst);
            if (ready_vec[ARB_RSP] && rsp_in_valid)     stat_rsp    <= sat_inc(stat_rsp);
            if (ready_vec[ARB_REQ] && req_in_valid)     stat_req    <= sat_inc(stat_req);
            if (ready_vec[ARB_DMA] && dma_req_in_valid) stat_dma    <= sat_inc(stat_dma);
            if (forced_pop)                             stat_forced <= sat_inc(stat_forced);
        end
    end
`endif

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Testbench for llc_input_arbiter. A behavioural model built from the
// priority rules predicts readies, gnt and busy on every cycle. Short
// directed sequences pin the model against hand-computed grant orders.
module tb_llc_input_arbiter;

    localparam int BURST = 4;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_tb_valid = 1'b0, rsp_in_valid = 1'b0, req_in_valid = 1'b0, dma_req_in_valid = 1'b0;
    logic req_stall = 1'b0, dma_stall = 1'b0, core_idle = 1'b0, core_done = 1'b0;
    logic rst_tb_ready, rsp_in_ready, req_in_ready, dma_req_in_ready;
    logic [3:0] gnt;
    logic busy;
`ifdef LLC_ARB_STATS_EN
    logic [CW-1:0] stat_rst, stat_rsp, stat_req, stat_dma, stat_forced;
`endif

    int checks = 0;
    int failures = 0;

    // Model state: held channel, preferred request channel (2=req, 3=dma), response run length
    bit m_busy = 0;
    int m_gnt = 0;
    int m_pref = 2;
    int m_burst = 0;

    int gq[$];

    int seq_burst[7] = '{1, 1, 1, 1, 2, 1, 1};
    int seq_rr[4]    = '{2, 3, 2, 3};
    int seq_stall[2] = '{3, 2};

    llc_input_arbiter #(.RSP_BURST_MAX(BURST), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rst_tb_valid     (rst_tb_valid),
        .rsp_in_valid     (rsp_in_valid),
        .req_in_valid     (req_in_valid),
        .dma_req_in_valid (dma_req_in_valid),
        .req_stall        (req_stall),
        .dma_stall        (dma_stall),
        .core_idle        (core_idle),
        .core_done        (core_done),
        .rst_tb_ready     (rst_tb_ready),
        .rsp_in_ready     (rsp_in_ready),
        .req_in_ready     (req_in_ready),
        .dma_req_in_ready (dma_req_in_ready),
        .gnt              (gnt),
        .busy             (busy)
`ifdef LLC_ARB_STATS_EN
        ,
        .stat_rst         (stat_rst),
        .stat_rsp         (stat_rsp),
        .stat_req         (stat_req),
        .stat_dma         (stat_dma),
        .stat_forced      (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model and compare, half a cycle away from the active edge
    always @(negedge clk) begin
        int pick;
        bit e1, e2, e3;
        logic [3:0] act_rdy, exp_rdy, exp_gnt;
        if (!rst) begin
            m_busy = 0; m_gnt = 0; m_pref = 2; m_burst = 0;
        end
        e1 = rsp_in_valid;
        e2 = req_in_valid && !req_stall;
        e3 = dma_req_in_valid && !dma_stall;
        pick = -1;
        if (rst && !m_busy && core_idle) begin
            if (rst_tb_valid) pick = 0;
            else if (m_burst == BURST && (e2 || e3)) pick = (e2 && e3) ? m_pref : (e2 ? 2 : 3);
            else if (e1) pick = 1;
            else if (e2 || e3) pick = (e2 && e3) ? m_pref : (e2 ? 2 : 3);
        end
        exp_rdy = (pick >= 0) ? 4'(1 << pick) : 4'd0;
        exp_gnt = m_busy ? 4'(1 << m_gnt) : 4'd0;
        act_rdy = {dma_req_in_ready, req_in_ready, rsp_in_ready, rst_tb_ready};
        check("model_ready", 32'(act_rdy), 32'(exp_rdy));
        check("model_gnt", 32'(gnt), 32'(exp_gnt));
        check("model_busy", 32'(busy), 32'(m_busy));
        for (int i = 0; i < 4; i++) begin
            if (act_rdy[i]) begin
                gq.push_back(i);
                break;
            end
        end
        if (rst) begin
            if (pick >= 0) begin
                m_busy = 1;
                m_gnt = pick;
                if (pick >= 2) begin
                    m_burst = 0;
                    m_pref = (pick == 2) ? 3 : 2;
                end else if (pick == 1) begin
                    m_burst = (e2 || e3) ? ((m_burst < BURST) ? m_burst + 1 : BURST) : 0;
                end
            end else if (m_busy && core_done) begin
                m_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst_tb_valid = 0; rsp_in_valid = 0; req_in_valid = 0; dma_req_in_valid = 0;
        req_stall = 0; dma_stall = 0; core_idle = 0; core_done = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        step();
        step();
        rst = 1;
        gq.delete();
    endtask

    // Act as the core: wait for a grant, hold it, then pulse core_done
    task automatic serve(input int n, input int hold);
        for (int t = 0; t < n; t++) begin
            int k = 0;
            while (!busy && k < 20) begin
                step();
                k++;
            end
            if (!busy) begin
                check("serve_timeout", 32'(busy), 32'd1);
                return;
            end
            repeat (hold - 1) step();
            core_done = 1;
            step();
            core_done = 0;
        end
    endtask

    initial begin
        // Reset state
        clear_inputs();
        step();
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'({dma_req_in_ready, req_in_ready, rsp_in_ready, rst_tb_ready}), 32'd0);

        // All valids after reset: rst_tb wins in cycle 0
        rst = 1;
        rst_tb_valid = 1; rsp_in_valid = 1; req_in_valid = 1; dma_req_in_valid = 1; core_idle = 1;
        #1;
        check("rst_first_ready", 32'({dma_req_in_ready, req_in_ready, rsp_in_ready, rst_tb_ready}), 32'b0001);
        step();
        check("rst_first_gnt", 32'(gnt), 32'b0001);
        check("rst_held_noready", 32'({dma_req_in_ready, req_in_ready, rsp_in_ready, rst_tb_ready}), 32'd0);
        serve(2, 3);

        // Response burst followed by one forced request slot
        do_reset();
        rsp_in_valid = 1; req_in_valid = 1; core_idle = 1;
        serve(7, 3);
        check("burst_count", 32'(gq.size()), 32'd7);
        for (int i = 0; i < 7 && i < gq.size(); i++) check($sformatf("burst_seq[%0d]", i), 32'(gq[i]), 32'(seq_burst[i]));
`ifdef LLC_ARB_STATS_EN
        check("stat_forced", 32'(stat_forced), 32'd1);
`endif

        // Round-robin between req and dma
        do_reset();
        req_in_valid = 1; dma_req_in_valid = 1; core_idle = 1;
        serve(4, 2);
        check("rr_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check($sformatf("rr_seq[%0d]", i), 32'(gq[i]), 32'(seq_rr[i]));

        // Stalled req lets dma through; releasing the stall brings req back
        do_reset();
        req_in_valid = 1; req_stall = 1; dma_req_in_valid = 1; core_idle = 1;
        serve(1, 2);
        req_stall = 0;
        serve(1, 2);
        check("stall_count", 32'(gq.size()), 32'd2);
        for (int i = 0; i < 2 && i < gq.size(); i++) check($sformatf("stall_seq[%0d]", i), 32'(gq[i]), 32'(seq_stall[i]));

        // Valids and stalls changing while BUSY; async reset mid-transaction
        do_reset();
        req_in_valid = 1; core_idle = 1;
        step();
        check("busy_gnt_req", 32'(gnt), 32'b0100);
        req_in_valid = 0; rsp_in_valid = 1; req_stall = 1;
        step();
        step();
        check("busy_no_ready", 32'(rsp_in_ready), 32'd0);
        check("busy_gnt_held", 32'(gnt), 32'b0100);
        core_done = 1;
        step();
        core_done = 0;
        check("ready_after_done", 32'(rsp_in_ready), 32'd1);
        step();
        check("gnt_rsp", 32'(gnt), 32'b0010);
        #1;
        rst = 0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        step();

        // core_done while idle is ignored; a valid that drops yields no grant
        do_reset();
        core_idle = 1;
        core_done = 1;
        step();
        core_done = 0;
        check("idle_done_busy", 32'(busy), 32'd0);
        rsp_in_valid = 1;
        #1;
        rsp_in_valid = 0;
        step();
        check("dropped_valid_busy", 32'(busy), 32'd0);

`ifdef LLC_ARB_STATS_EN
        do_reset();
        req_in_valid = 1; core_idle = 1;
        serve(10, 1);
        check("stat_req_10", 32'(stat_req), 32'd10);
        do_reset();
        rsp_in_valid = 1; core_idle = 1;
        serve(255, 1);
        check("stat_rsp_max", 32'(stat_rsp), 32'hff);
        serve(1, 1);
        check("stat_rsp_sat", 32'(stat_rsp), 32'hff);
`endif

        do_reset();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
- Chooses which LLC input channel the core's DECODE stage consumes next: testbench reset, coherence response, coherence request or DMA request.
- Holds the chosen grant until the core signals the transaction has finished UPDATE, then re-arbitrates.
- Enforces fixed priority with anti-starvation of requests behind responses, and round-robin between the CPU and DMA request channels.
- Sits between the input buffers and the core's decode/ready logic.

Parameters:
- RSP_BURST_MAX, 4, max consecutive rsp grants while a req/dma is valid and unblocked before one request slot is forced.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rst_tb_valid  in  1  testbench reset request pending
- rsp_in_valid  in  1  coherence response pending
- req_in_valid  in  1  CPU coherence request pending
- dma_req_in_valid  in  1  DMA request pending
- req_stall  in  1  core is blocking new CPU requests (recall/flush pending)
- dma_stall  in  1  core is blocking new DMA requests
- core_idle  in  1  core is in DECODE and can accept a transaction
- core_done  in  1  one-cycle pulse when the core leaves UPDATE
- rst_tb_ready  out  1  pop rst_tb channel
- rsp_in_ready  out  1  pop rsp channel
- req_in_ready  out  1  pop req channel
- dma_req_in_ready  out  1  pop dma channel
- gnt  out  4  one-hot held grant {dma,req,rsp,rst}; 0 when idle
- busy  out  1  a transaction is in flight

Behaviour:
- Reset state (rst low, asynchronous): state=IDLE; gnt=0; busy=0; all readies 0; rr_ptr=0 (req preferred); rsp_burst=0.
- Ready outputs are combinational: asserted only in IDLE with core_idle=1; at most one per cycle.
- Channel eligibility:
  - rst, rsp: valid.
  - req: valid & !req_stall.
  - dma: valid & !dma_stall.
- Priority order, first match wins:
  - 1. rst_tb.
  - 2. Forced request slot: rsp_burst==RSP_BURST_MAX and req or dma is eligible; pick by rr_ptr.
  - 3. rsp.
  - 4. req/dma round-robin: if both are eligible, take the one rr_ptr selects; otherwise take whichever is eligible.
- The selected channel's ready is driven in the same cycle; the channel pops on valid&ready.
- FSM:
  - IDLE -> BUSY on any grant; gnt is latched to the selected one-hot and busy=1 on the next edge.
  - BUSY -> IDLE on core_done; gnt cleared to 0 and busy=0 on that edge.
  - In BUSY all readies are 0, independent of core_idle.
- Decision-latency rules:
  - A grant takes 0 cycles from core_idle.
  - A new grant may follow at earliest the cycle after core_done, i.e. the cycle IDLE is re-entered with core_idle=1.
- rr_ptr: toggles only when req or dma is granted; set to point at the other of the two request channels.
- rsp_burst (saturating at RSP_BURST_MAX):
  - Increments on an rsp grant while req or dma is eligible.
  - Clears on any req/dma grant.
  - Clears on an rsp grant while no request is eligible.
  - Unchanged on an rst_tb grant.
- core_done while IDLE: ignored, no state change.
- core_done in the same cycle as a would-be grant: none possible, because grants only occur in IDLE.
- Stall/valid changes:
  - Stalls asserted while BUSY do not affect the held gnt.
  - A valid that drops while IDLE causes no grant that cycle.
- Asynchronous reset mid-transaction returns to IDLE immediately; no pending grant is remembered.

Optional Feature:
- Macro LLC_ARB_STATS_EN.
- When defined:
  - Adds four CNT_W-bit output ports: stat_rst, stat_rsp, stat_req, stat_dma.
  - Each increments on its channel's ready&valid, saturates at all-ones and resets to 0.
  - Adds stat_forced (CNT_W bits), counting forced request slots.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared cache package (alongside the existing LLC typedefs) gains:
  - arb_gnt_t, a 4-bit one-hot.
  - Channel index constants ARB_RST=0, ARB_RSP=1, ARB_REQ=2, ARB_DMA=3.
  - Default LLC_ARB_RSP_BURST_MAX.
- One natural sub-module: llc_arb_rr2, a 2-way round-robin picker with pointer register and update enable, used for the req/dma choice.

Test Plan:
- After reset, all four valids high, core_idle=1 -> rst_tb_ready in cycle 0; gnt=4'b0001 next cycle; no further ready until core_done.
- rsp and req both valid continuously, RSP_BURST_MAX=4, core_done every 3 cycles -> grant sequence rsp,rsp,rsp,rsp,req,rsp,…; rsp_burst resets after the req grant.
- req and dma both valid, no rsp -> grants alternate req,dma,req,dma starting with req after reset.
- req valid with req_stall=1, dma valid -> dma granted; drop req_stall -> next grant is req.
- While BUSY raise rsp_in_valid and hold core_idle=1 -> no ready until the cycle after the core_done pulse; rst low mid-BUSY -> gnt=0, busy=0 immediately.
- With LLC_ARB_STATS_EN: 10 req pops -> stat_req=10; run stat_rsp to all-ones and apply one more rsp pop -> it holds at all-ones.
